// File: rtl/vga_char_sink.sv
// Video-side sink for CPU character writes: edge-captures videoflag into a small FIFO,
// drains it into the framebuffer write port around fb_busy, and runs full-screen clears.
module vga_char_sink #(
  parameter int          DEPTH      = 8,
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter int          ADDR_W     = 11,
  parameter logic [15:0] CLEAR_CHAR = 16'h0000
) (
  input  logic                       wire_clock,
  input  logic                       wire_reset,
  input  logic                       videoflag,
  input  logic [15:0]                bus_vga_pos,
  input  logic [15:0]                bus_vga_char,
  input  logic                       clear_req,
  input  logic                       fb_busy,
  output logic                       fb_we,
  output logic [ADDR_W-1:0]          fb_addr,
  output logic [15:0]                fb_data,
  output logic                       clearing,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 drop_count
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int NCELL = COLS * ROWS;

  typedef struct packed {
    logic [ADDR_W-1:0] pos;
    logic [15:0]       chr;
  } wr_req_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  wr_req_t           mem [DEPTH];
  wr_req_t           req;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              vf_q;
  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  logic push_req, pos_ok, flush, pop, full, push_acc, drop;

  always_comb begin
    req.pos  = bus_vga_pos[ADDR_W-1:0];
    req.chr  = bus_vga_char;
    push_req = videoflag & ~vf_q;
    pos_ok   = bus_vga_pos < 16'(NCELL);
    flush    = (state == IDLE) & clear_req;
    // a clear request owns the cycle, so no pop competes with the flush
    pop      = (state == IDLE) & ~clear_req & (fifo_count != '0) & ~fb_busy;
    full     = fifo_count == CW'(DEPTH);
    push_acc = push_req & pos_ok & (flush | ~full | pop);
    drop     = push_req & ~push_acc;
  end

  // storage carries no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge wire_clock) begin
    if (push_acc) mem[flush ? '0 : wr_ptr] <= req;
  end

  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      vf_q       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
      state      <= IDLE;
      clr_cnt    <= '0;
      clearing   <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
    end else begin
      vf_q <= videoflag;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;

      if (flush) begin
        wr_ptr     <= PW'(push_acc);
        rd_ptr     <= '0;
        fifo_count <= CW'(push_acc);
      end else begin
        wr_ptr     <= wr_ptr + PW'(push_acc);
        rd_ptr     <= rd_ptr + PW'(pop);
        fifo_count <= fifo_count + CW'(push_acc) - CW'(pop);
      end

      fb_we <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clearing <= 1'b1;
          end else begin
            // clearing drops one cycle after the final clear write appears
            clearing <= 1'b0;
            if (pop) begin
              fb_we   <= 1'b1;
              fb_addr <= mem[rd_ptr].pos;
              fb_data <= mem[rd_ptr].chr;
            end
          end
        end
        CLEAR: begin
          if (!fb_busy) begin
            fb_we   <= 1'b1;
            fb_addr <= clr_cnt;
            fb_data <= CLEAR_CHAR;
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == ADDR_W'(NCELL - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
